// File: rtl/if_fetch_queue.sv
// Prefetching instruction-fetch front end: issues sequential fetches, buffers PC-tagged responses.
// Latency: a response is visible at the queue head one cycle after it arrives (no bypass).
// Backpressure: requests are credit-limited so in-flight plus queued never exceeds DEPTH.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_addr     : fetch request to the instruction memory
//   resp_valid/resp_data             : in-order memory responses, never stalled
//   redirect/redirect_addr           : flush queued and in-flight fetches, restart at new PC
//   out_valid/out_ready/out_inst/out_pc : queue head towards decode
module if_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  // Counters hold 0..DEPTH; two extra bits keep the three-way credit sum from overflowing.
  localparam int CW = PW + 2;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         live_q, live_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic req_hs;
  logic drop;   // response consumed by a pending discard
  logic keep;   // response belongs to a live fetch
  logic push;
  logic pop;

  // Every slot in the queue is pre-reserved at issue time, so a push can never hit a full queue.
  assign req_valid = rst && !redirect && ((live_q + discard_q + count_q) < CW'(DEPTH));
  assign req_addr  = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];

  assign req_hs = req_valid && req_ready;
  assign drop   = resp_valid && (discard_q != '0);
  assign keep   = resp_valid && (discard_q == '0) && (live_q != '0);
  assign push   = keep && !redirect;
  assign pop    = out_valid && out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q + CW'(req_hs) - CW'(keep);
    discard_d  = discard_q - CW'(drop);
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_hs) fetch_pc_d = fetch_pc_q + STRIDE;
    if (keep)   resp_pc_d  = resp_pc_q + STRIDE;
    if (push)   wr_ptr_d   = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d   = rd_ptr_q + PW'(1);

    if (redirect) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      // All live fetches become discards; a response landing this cycle retires one of
      // them already. No request can issue while redirect is high.
      discard_d  = discard_q + live_q - CW'(drop | keep);
      live_d     = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        inst_q[wr_ptr_q] <= resp_data;
        pc_q[wr_ptr_q]   <= resp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: three instances (DEPTH 2, 4, 8) run the same phase schedule,
// each with its own memory model, reference model and scoreboard.
module tb_if_fetch_queue;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  typedef struct {logic [31:0] a; bit kept;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {logic [31:0] a; int due;} mp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_d
    localparam int D = 2 << g;

    logic        rst, req_valid, req_ready, resp_valid, redirect, out_valid, out_ready;
    logic [31:0] req_addr, resp_data, redirect_addr, out_inst, out_pc;

    fl_t  inflight[$];   // issued fetches, oldest first; kept=0 once flushed
    ent_t expq[$];       // expected queue contents, head first
    mp_t  pipe[$];       // memory pipeline
    fl_t  f;
    ent_t en;
    logic [31:0] exp_pc = RPC;
    int  e = 0, lat = 1, hs_cnt = 0;
    int  mvec = 0, merr = 0, dvec = 0, derr = 0;
    bit  rst_edge = 1'b0, done = 1'b0;

    if_fetch_queue #(.DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .redirect(redirect), .redirect_addr(redirect_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
    );

    task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      mvec++;
      if (act !== exp) begin
        merr++;
        $display("FAIL d%0d %s: got %h want %h", D, nm, act, exp);
      end
    endtask

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      dvec++;
      if (act !== exp) begin
        derr++;
        $display("FAIL d%0d %s: got %h want %h", D, nm, act, exp);
      end
    endtask

    // Monitor: compares DUT outputs against the model state after the previous edge.
    always @(negedge clk) begin
      if (rst_edge && !rst) begin
        mchk("rst_req_valid", 32'(req_valid), 32'd0);
        mchk("rst_req_addr", req_addr, RPC);
        mchk("rst_out_valid", 32'(out_valid), 32'd0);
        mchk("rst_out_inst", out_inst, 32'd0);
        mchk("rst_out_pc", out_pc, 32'd0);
      end else if (rst) begin
        mchk("out_valid", 32'(out_valid), 32'(expq.size() != 0));
        mchk("req_valid", 32'(req_valid),
             32'(!redirect && (inflight.size() + expq.size() < D)));
        if (req_valid) mchk("req_addr", req_addr, exp_pc);
        if (out_valid && expq.size() != 0) begin
          mchk("out_pc", out_pc, expq[0].pc);
          mchk("out_inst", out_inst, expq[0].inst);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end

    // Reference model: applies the effects of the coming edge.
    always @(negedge clk) begin
      #1;
      rst_edge = !rst;
      if (!rst) begin
        inflight.delete();
        expq.delete();
        exp_pc = RPC;
      end else begin
        if (resp_valid && inflight.size() != 0) begin
          f = inflight.pop_front();
          if (f.kept && !redirect) begin
            en.pc   = f.a;
            en.inst = memf(f.a);
            expq.push_back(en);
          end
        end
        if (redirect) begin
          foreach (inflight[i]) inflight[i].kept = 1'b0;
          expq.delete();
          exp_pc = redirect_addr;
        end
        if (req_valid && req_ready) begin
          f.a = exp_pc;
          f.kept = 1'b1;
          inflight.push_back(f);
          pipe.push_back('{a: req_addr, due: e + 1 + lat});
          exp_pc = exp_pc + 32'd4;
          hs_cnt++;
        end
      end
    end

    // Drive one cycle of inputs, memory responses taken from the pipeline.
    task automatic cyc(input bit rs, input bit rr, input bit orr, input bit rd,
                       input logic [31:0] ra);
      rst = rs; req_ready = rr; out_ready = orr; redirect = rd; redirect_addr = ra;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (!rs) pipe.delete();
      else if (pipe.size() != 0 && pipe[0].due <= e + 1) begin
        resp_valid = 1'b1;
        resp_data  = memf(pipe[0].a);
        void'(pipe.pop_front());
      end
      @(posedge clk);
      #1;
      e++;
    endtask

    initial begin
      logic [31:0] hold;
      int h0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      lat = 1;
      repeat (20) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

      // req_ready stall: address holds while the queue drains
      hold = req_addr;
      repeat (12) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      dchk("stall_addr_hold", req_addr, hold);
      dchk("drained", 32'(out_valid), 32'd0);

      // backpressure fill from empty
      h0 = hs_cnt;
      repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      dchk("fill_reqs", 32'(hs_cnt - h0), 32'(D));
      dchk("fill_req_valid", 32'(req_valid), 32'd0);
      dchk("fill_out_valid", 32'(out_valid), 32'd1);
      h0 = hs_cnt;
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      dchk("release_one", 32'(hs_cnt - h0), 32'd1);

      // redirects with deep memory: in-flight, queued, coincident response/pop
      lat = 3;
      repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_1000);
      repeat (15) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_2000);
      repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      // address wrap past all-ones
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

      // randomized traffic with a mid-run reset
      for (int i = 0; i < 400; i++) begin
        if (i % 50 == 0) lat = int'($urandom_range(1, 3));
        if (i == 200 || i == 201) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        else cyc(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3),
                 ($urandom_range(0, 19) == 0), ($urandom & 32'hFFFF_FFFC));
      end
      repeat (20) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int vec, err, c;
    c = 0;
    while (!(g_d[0].done && g_d[1].done && g_d[2].done) && c < 20000) begin
      @(posedge clk);
      c++;
    end
    vec = g_d[0].mvec + g_d[1].mvec + g_d[2].mvec + g_d[0].dvec + g_d[1].dvec + g_d[2].dvec;
    err = g_d[0].merr + g_d[1].merr + g_d[2].merr + g_d[0].derr + g_d[1].derr + g_d[2].derr;
    vec++;
    if (c >= 20000) begin
      err++;
      $display("FAIL timeout: got %0d cycles want < 20000", c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end that replaces the single-register PC stage with a prefetching fetch engine. It issues sequential fetch requests to a pipelined instruction memory and buffers in-order responses, tagged with their PC, in a DEPTH-entry queue. It also redirects on branch or exception with flushing of queued and in-flight fetches. It sits between the instruction memory port and the decode stage, and decouples fetch latency from decode stalls.

## Interface
- ADDR_WIDTH, 32, fetch address / PC width
- DATA_WIDTH, 32, instruction word width; PC stride is DATA_WIDTH/8
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, >= 2
- RESET_PC, 32'hBFC0_0000, first fetch address after reset

- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-low reset (rst = 0 resets)
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_WIDTH  fetch address (current fetch PC register)
- resp_valid  in  1  response valid; strictly in request order, no backpressure
- resp_data  in  DATA_WIDTH  fetched instruction
- redirect  in  1  flush and restart fetch
- redirect_addr  in  ADDR_WIDTH  new fetch PC
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_inst  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  head PC

## Operation
- State: fetch_pc, resp_pc, live counter (in-flight, kept), discard counter (in-flight, dropped), queue (inst+PC), rd/wr pointers, count (0..DEPTH).
- Issue: req_valid = rst && !redirect && (live + discard + count < DEPTH). req_addr = fetch_pc. Handshake (req_valid && req_ready): fetch_pc += DATA_WIDTH/8, live++.
- Response: if discard != 0: discard--, data dropped. Else if live != 0: push {resp_data, resp_pc}, resp_pc += stride, live--. A response with live = discard = 0 is ignored.
- Pop: out_valid && out_ready -> rd_ptr++, count--. out_valid = (count != 0). out_inst/out_pc = head entry.
- Redirect (cycle with redirect = 1):
  - fetch_pc <= redirect_addr and resp_pc <= redirect_addr.
  - The queue is emptied (count <= 0, pointers reset equal).
  - discard <= discard + live minus any same-cycle response; the response in that cycle is dropped. live <= 0.
  - A pop in the same cycle completes; the decode stage owns delay-slot handling and asserts redirect only after the delay slot has been popped.
- Push and pop in the same cycle: count unchanged. Full queue with push cannot occur because of the credit rule.
- Pointer width is log2(DEPTH); pointers wrap naturally.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to zero is silent.

## Timing
- Reset (rst = 0 at an edge):
  - fetch_pc = resp_pc = RESET_PC.
  - Counters, pointers and count are 0; queue storage is 0.
  - Outputs: req_valid 0, req_addr RESET_PC, out_valid 0, out_inst 0, out_pc 0.
- First request: req_valid = 1 in the first cycle with rst = 1.
- Reset mid-operation: everything returns to reset state; responses to pre-reset requests are the memory's responsibility to squash.
- Latency:
  - resp_valid at edge N gives out_valid = 1 after edge N (registered, no bypass).
  - redirect at edge N gives req_addr = redirect_addr and req_valid = 1 after edge N, provided credit is available.
- Throughput: one request, one response and one pop per cycle when memory latency + 1 <= DEPTH.
- req_valid may drop without handshake (credit, redirect); memory must tolerate this.

## Test plan
- Reset/stream:
  - Stimulus: rst low 2 cycles, then high; memory with 1-cycle latency, req_ready = 1, out_ready = 1.
  - Required: req_addr sequence BFC00000, BFC00004, ...; out_pc follows the same sequence 2 cycles behind; one pop per cycle.
- Backpressure fill:
  - Stimulus: out_ready = 0, DEPTH = 4.
  - Required: exactly 4 requests issued; count = 4; req_valid stays 0.
  - Then out_ready = 1 for 1 cycle: exactly one new request is issued next cycle.
- Redirect with in-flight:
  - Stimulus: 3-cycle memory latency, 2 live fetches, 1 queued entry; redirect to 0x80001000.
  - Required: queue empty; the next 2 responses are dropped; first out_pc = 0x80001000.
- Redirect coincident with response and pop:
  - Required: the popped head is delivered; the arriving response is dropped; discard = live - 1.
- req_ready stall:
  - Stimulus: req_ready = 0 for 5 cycles.
  - Required: req_addr holds its value; no fetch_pc advance; no spurious push.
- Pointer wrap and parameters:
  - Stimulus: 20 sequential instructions with random out_ready, DEPTH = 2 and DEPTH = 8.
  - Required: in-order out_inst/out_pc with no loss or duplication.
